// File: rtl/vmicro16_apb_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vmicro16_apb_rr_arbiter_pkg
// Description : Shared state encoding, defaults and width helper for the
//               APB round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vmicro16_apb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam int c_TIMEOUT_DEFAULT = 255;

  // Index width that never collapses to zero bits for a single requester.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vmicro16_apb_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : vmicro16_apb_rr_arbiter_if
// Description : Upstream (S_*) and downstream (M_*) APB signals of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface vmicro16_apb_rr_arbiter_if #(
  parameter int MASTERS    = 4,
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
);
  logic [MASTERS*BUS_WIDTH-1:0]  S_PADDR;
  logic [MASTERS-1:0]            S_PWRITE;
  logic [MASTERS-1:0]            S_PSELx;
  logic [MASTERS-1:0]            S_PENABLE;
  logic [MASTERS*DATA_WIDTH-1:0] S_PWDATA;
  logic [MASTERS*DATA_WIDTH-1:0] S_PRDATA;
  logic [MASTERS-1:0]            S_PREADY;

  logic [BUS_WIDTH-1:0]          M_PADDR;
  logic                          M_PWRITE;
  logic                          M_PSELx;
  logic                          M_PENABLE;
  logic [DATA_WIDTH-1:0]         M_PWDATA;
  logic [DATA_WIDTH-1:0]         M_PRDATA;
  logic                          M_PREADY;

  // Arbiter view: serves the requesters, drives the downstream port.
  modport slave (
    input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, M_PRDATA, M_PREADY,
    output S_PRDATA, S_PREADY, M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
  );

  // Environment view: requesters plus the downstream slave.
  modport master (
    output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, M_PRDATA, M_PREADY,
    input  S_PRDATA, S_PREADY, M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
  );
endinterface
`default_nettype wire

// File: rtl/vmicro16_apb_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : vmicro16_rr_pick
// Description : Combinational round-robin picker; first request at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module vmicro16_rr_pick #(
  parameter int MASTERS = 4,
  parameter int PW      = 2
) (
  input  logic [MASTERS-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic               valid,
  output logic [PW-1:0]      idx
);

  int k;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    k     = 0;
    for (int i = 0; i < MASTERS; i++) begin
      k = int'(ptr) + i;
      if (k >= MASTERS) k = k - MASTERS;
      if (!valid && req[k]) begin
        valid = 1'b1;
        idx   = PW'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vmicro16_apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vmicro16_apb_rr_arbiter
// Description : Round-robin whole-transfer APB arbiter with ACCESS watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module vmicro16_apb_rr_arbiter
  import vmicro16_apb_rr_arbiter_pkg::*;
#(
  parameter int MASTERS    = 4,
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = c_TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  vmicro16_apb_rr_arbiter_if.slave bus,
  output logic [MASTERS-1:0]       grant,
  output logic                     timeout_err
);

  localparam int c_PW = clog2_min1(MASTERS);
  localparam int c_CW = $clog2(TIMEOUT + 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_PW-1:0]         r_ptr;
  logic [c_PW-1:0]         r_g;
  logic [c_CW-1:0]         r_cnt;
  logic [BUS_WIDTH-1:0]    r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic                    r_pwrite;

  logic                    w_pick_valid;
  logic [c_PW-1:0]         w_pick_idx;
  logic                    w_timeout;
  logic                    w_done;
  logic [c_PW-1:0]         w_ptr_nxt;
  logic [MASTERS-1:0]            w_pready;
  logic [MASTERS*DATA_WIDTH-1:0] w_prdata;

  vmicro16_rr_pick #(
    .MASTERS (MASTERS),
    .PW      (c_PW)
  ) u_pick (
    .req   (bus.S_PSELx),
    .ptr   (r_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  // A ready slave always beats the watchdog in the same cycle.
  assign w_timeout = (r_state == ST_ACCESS) && !bus.M_PREADY &&
                     (r_cnt == c_CW'(TIMEOUT - 1));
  assign w_done    = (r_state == ST_ACCESS) && (bus.M_PREADY || w_timeout);
  assign w_ptr_nxt = (r_g == c_PW'(MASTERS - 1)) ? '0 : r_g + c_PW'(1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_pick_valid) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (w_done) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_g      <= '0;
      r_cnt    <= '0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_pick_valid) begin
        r_g      <= w_pick_idx;
        r_paddr  <= bus.S_PADDR[w_pick_idx*BUS_WIDTH +: BUS_WIDTH];
        r_pwdata <= bus.S_PWDATA[w_pick_idx*DATA_WIDTH +: DATA_WIDTH];
        r_pwrite <= bus.S_PWRITE[w_pick_idx];
      end
      if (r_state == ST_SETUP)
        r_cnt <= '0;
      else if (r_state == ST_ACCESS && !w_done)
        r_cnt <= r_cnt + c_CW'(1);
      if (w_done)
        r_ptr <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_pready = '0;
    w_prdata = '0;
    grant    = '0;
    if (r_state != ST_IDLE)
      grant[r_g] = 1'b1;
    if (r_state == ST_ACCESS) begin
      w_pready[r_g] = bus.M_PREADY || w_timeout;
      w_prdata[r_g*DATA_WIDTH +: DATA_WIDTH] = w_timeout ? '0 : bus.M_PRDATA;
    end
  end

  assign timeout_err   = w_timeout;
  assign bus.S_PREADY  = w_pready;
  assign bus.S_PRDATA  = w_prdata;
  assign bus.M_PSELx   = (r_state != ST_IDLE);
  assign bus.M_PENABLE = (r_state == ST_ACCESS);
  assign bus.M_PADDR   = r_paddr;
  assign bus.M_PWDATA  = r_pwdata;
  assign bus.M_PWRITE  = r_pwrite;

endmodule
`default_nettype wire
